mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port memory between two requesters that use the processor's strobe-style bus (addr/rstrb/wmask/wdata/rdata).
//  Port 0 is the processor. Port 1 is a secondary master (program loader, DMA or debug).
//  Captures one-cycle request strobes and arbitrates between pending requests.
//  Sequences each memory access and returns read data and busy status per port.
// PARAMETERS
//  XLEN       32  data width; also address width
//  PRIO_FIXED 0   0: round-robin on ties; 1: port 0 always wins ties
// PORTS
//  clk        in   1     single clock, rising edge
//  resetn     in   1     asynchronous, active-low reset
//  pN_addr    in   XLEN  port N byte address (N = 0,1), sampled on strobe cycle
//  pN_rstrb   in   1     port N one-cycle read strobe
//  pN_wmask   in   4     port N byte write mask; nonzero = one-cycle write strobe
//  pN_wdata   in   XLEN  port N write data, already lane-aligned, sampled on strobe
//  pN_rdata   out  XLEN  port N read data, held until port N's next read completes
//  pN_rbusy   out  1     port N read pending/in progress
//  pN_wbusy   out  1     port N write pending/in progress
//  mem_addr   out  XLEN  memory address
//  mem_rstrb  out  1     memory read strobe; mem_rdata valid the following cycle
//  mem_wmask  out  4     memory byte write enables, active for exactly one cycle
//  mem_wdata  out  XLEN  memory write data
//  mem_rdata  in   XLEN  memory read data, one cycle after mem_rstrb
// BEHAVIOUR
//  - Reset (async): state IDLE, both request buffers empty, all outputs 0, last_grant = 1 (port 0 wins the first tie).
//  - Capture: a strobe is accepted only when the port's rbusy and wbusy are both 0. Accepted strobe latches addr/wdata/wmask/kind into the port buffer at the clock edge.
//  - A strobe while busy is ignored; no side effects. If rstrb and wmask != 0 arrive together, the request is a write and rstrb is ignored.
//  - Busy flags: rbusy/wbusy go high the cycle after an accepted strobe and stay high until completion.
//  - FSM, one access at a time:
//      IDLE:  if any buffer is pending, register grant and go to READ or WRITE by kind; else stay.
//      READ:  mem_rstrb = 1 and mem_addr = buffer addr for one cycle -> READ_WAIT.
//      READ_WAIT: at end of cycle, pN_rdata <= mem_rdata, clear buffer and rbusy -> IDLE.
//      WRITE: mem_wmask = buffer wmask, drive mem_addr/mem_wdata; at end of cycle clear buffer and wbusy -> IDLE.
//  - Uncontended latency, strobe in cycle 0:
//      read: rbusy high cycles 1-3, mem_rstrb in cycle 2, rdata valid and rbusy 0 from cycle 4.
//      write: wbusy high cycles 1-2, mem_wmask in cycle 2.
//  - Ties in IDLE: PRIO_FIXED = 0 grants the port that is not last_grant; PRIO_FIXED = 1 grants port 0. last_grant updates on every grant.
//  - Round-robin bound: a pending request waits at most one other access.
//  - Memory outputs outside READ/WRITE: mem_rstrb = 0 and mem_wmask = 0. mem_addr/mem_wdata hold their last driven value (0 after reset).
//  - A port may re-strobe in the cycle its busy flag reads 0; the request is captured that edge.
//  - Reset mid-access: access aborted, mem_wmask/mem_rstrb drop immediately, no completion is reported, rdata returns to 0.
// STRUCTURE
//  - Shared package mem_arb_pkg: FSM state localparams (IDLE, READ, READ_WAIT, WRITE) and request-kind encoding (KIND_READ, KIND_WRITE).
//  - Sub-module mem_arb_req_buf, instantiated per port. It holds the strobe capture, busy flags and pending addr/wdata/wmask/kind, plus a clear input.
//  - Top level holds the FSM, grant/last_grant logic, memory muxing and rdata registers.
// TESTING
//  1. p0 read 0x100 with memory returning 0xDEADBEEF -> mem_rstrb high only in cycle 2 with addr 0x100; p0_rbusy high cycles 1-3; p0_rdata = 0xDEADBEEF from cycle 4.
//  2. After reset, same cycle: p0 read 0x10 and p1 write 0x20/0x12345678/0xF -> p0 read issued first; mem_wmask = 0xF at 0x20 in cycle 5; p1_wbusy falls in cycle 6.
//  3. PRIO_FIXED = 0, both ports re-strobe reads as soon as not busy -> grants alternate 0,1,0,1 and neither port waits more than one access.
//  4. PRIO_FIXED = 1, same stimulus as 3 -> port 0 wins every tie; p1 is served only in IDLE cycles where p0 has nothing pending.
//  5. p1 write wmask 0x2, wdata 0x0000AB00, addr 0x41; second p1 strobe while wbusy -> one memory write with mem_wmask = 0x2 and data passed unchanged; the second strobe is dropped.
//  6. resetn low during READ -> mem_rstrb, busy flags and rdata are 0 immediately; after release no completion occurs and the FSM stays IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, request kinds
// and the tie-break rule used when both ports are pending.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ      = 2'd1,
    READ_WAIT = 2'd2,
    WRITE     = 2'd3
  } arb_state_t;

  typedef enum logic {
    KIND_READ  = 1'b0,
    KIND_WRITE = 1'b1
  } req_kind_t;

  localparam int NUM_PORTS = 2;

  // Port to serve next; on a tie round-robin hands it to whoever did not go last.
  function automatic logic pick_port(input logic pend0,
                                     input logic pend1,
                                     input logic last_grant,
                                     input logic prio_fixed);
    logic sel;
    if (pend0 && pend1) begin
      sel = prio_fixed ? 1'b0 : ~last_grant;
    end else begin
      sel = pend1 && !pend0;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Strobe-style requester bus: one-cycle rstrb / nonzero wmask strobes,
// read data held by the slave, busy flags per access kind.
interface mem_arbiter_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] addr;
  logic            rstrb;
  logic [3:0]      wmask;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;
  logic            rbusy;
  logic            wbusy;

  modport master (
    output addr, rstrb, wmask, wdata,
    input  rdata, rbusy, wbusy
  );

  modport slave (
    input  addr, rstrb, wmask, wdata,
    output rdata, rbusy, wbusy
  );
endinterface

// File: rtl/mem_arb_req_buf.sv
// One-deep request buffer for a single port: captures a strobe while idle,
// holds it with the matching busy flag until the arbiter clears it.
module mem_arb_req_buf
  import mem_arb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            rstrb,
  input  logic [3:0]      wmask,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  logic            clear,
  output logic            pending,
  output req_kind_t       kind,
  output logic [XLEN-1:0] req_addr,
  output logic [XLEN-1:0] req_wdata,
  output logic [3:0]      req_wmask,
  output logic            rbusy,
  output logic            wbusy
);

  logic is_wr;
  logic accept;

  // A write strobe takes precedence over a simultaneous read strobe.
  assign is_wr   = |wmask;
  assign accept  = !rbusy && !wbusy && (rstrb || is_wr);
  assign pending = rbusy | wbusy;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rbusy     <= 1'b0;
      wbusy     <= 1'b0;
      kind      <= KIND_READ;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wmask <= '0;
    end else if (accept) begin
      rbusy     <= !is_wr;
      wbusy     <= is_wr;
      kind      <= is_wr ? KIND_WRITE : KIND_READ;
      req_addr  <= addr;
      req_wdata <= wdata;
      req_wmask <= wmask;
    end else if (clear) begin
      rbusy <= 1'b0;
      wbusy <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port memory with one-cycle read latency.
// state     | meaning
// IDLE      | pick a pending port, launch its access
// READ      | mem_rstrb asserted for the granted port
// READ_WAIT | memory returns data; latch into the port's rdata, release port
// WRITE     | mem_wmask asserted for one cycle; release port
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int PRIO_FIXED = 0
) (
  input  logic            clk,
  input  logic            resetn,
  mem_arbiter_if.slave    p0,
  mem_arbiter_if.slave    p1,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_rstrb,
  output logic [3:0]      mem_wmask,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  arb_state_t      state;
  logic            grant;
  logic            last_grant;
  logic            nxt_grant;
  logic            done;
  logic [1:0]      pend;
  logic [1:0]      clr;
  logic [1:0]      b_rbusy;
  logic [1:0]      b_wbusy;
  req_kind_t       b_kind  [NUM_PORTS];
  logic [XLEN-1:0] b_addr  [NUM_PORTS];
  logic [XLEN-1:0] b_wdata [NUM_PORTS];
  logic [3:0]      b_wmask [NUM_PORTS];
  logic [XLEN-1:0] rdata_q [NUM_PORTS];

  mem_arb_req_buf #(.XLEN(XLEN)) u_buf0 (
    .clk       (clk),
    .resetn    (resetn),
    .rstrb     (p0.rstrb),
    .wmask     (p0.wmask),
    .addr      (p0.addr),
    .wdata     (p0.wdata),
    .clear     (clr[0]),
    .pending   (pend[0]),
    .kind      (b_kind[0]),
    .req_addr  (b_addr[0]),
    .req_wdata (b_wdata[0]),
    .req_wmask (b_wmask[0]),
    .rbusy     (b_rbusy[0]),
    .wbusy     (b_wbusy[0])
  );

  mem_arb_req_buf #(.XLEN(XLEN)) u_buf1 (
    .clk       (clk),
    .resetn    (resetn),
    .rstrb     (p1.rstrb),
    .wmask     (p1.wmask),
    .addr      (p1.addr),
    .wdata     (p1.wdata),
    .clear     (clr[1]),
    .pending   (pend[1]),
    .kind      (b_kind[1]),
    .req_addr  (b_addr[1]),
    .req_wdata (b_wdata[1]),
    .req_wmask (b_wmask[1]),
    .rbusy     (b_rbusy[1]),
    .wbusy     (b_wbusy[1])
  );

  assign nxt_grant = pick_port(pend[0], pend[1], last_grant, PRIO_FIXED != 0);
  assign done      = (state == READ_WAIT) || (state == WRITE);
  assign clr[0]    = done && !grant;
  assign clr[1]    = done && grant;

  assign p0.rdata = rdata_q[0];
  assign p0.rbusy = b_rbusy[0];
  assign p0.wbusy = b_wbusy[0];
  assign p1.rdata = rdata_q[1];
  assign p1.rbusy = b_rbusy[1];
  assign p1.wbusy = b_wbusy[1];

  // Memory strobes are registered on the IDLE exit so they line up with READ/WRITE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      mem_addr   <= '0;
      mem_rstrb  <= 1'b0;
      mem_wmask  <= '0;
      mem_wdata  <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|pend) begin
            grant      <= nxt_grant;
            last_grant <= nxt_grant;
            mem_addr   <= b_addr[nxt_grant];
            if (b_kind[nxt_grant] == KIND_WRITE) begin
              mem_wmask <= b_wmask[nxt_grant];
              mem_wdata <= b_wdata[nxt_grant];
              state     <= WRITE;
            end else begin
              mem_rstrb <= 1'b1;
              state     <= READ;
            end
          end
        end
        READ: begin
          mem_rstrb <= 1'b0;
          state     <= READ_WAIT;
        end
        READ_WAIT: begin
          rdata_q[grant] <= mem_rdata;
          state          <= IDLE;
        end
        WRITE: begin
          mem_wmask <= '0;
          state     <= IDLE;
        end
        default: begin
          mem_rstrb <= 1'b0;
          mem_wmask <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: round-robin and fixed-priority instances share stimulus;
// each has its own memory and a cycle-timeline reference model.
module tb_mem_arbiter;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int tc       = 0;

  logic        s_rstrb [2];
  logic [3:0]  s_wmask [2];
  logic [31:0] s_addr  [2];
  logic [31:0] s_wdata [2];

  function automatic logic [31:0] mem_default(input logic [29:0] widx);
    return {16'hC0DE, widx[13:0], 2'b00};
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, inst, $time, got, exp);
    end
  endtask

  function automatic int pack_log(input int q[$]);
    int v = 0;
    foreach (q[i]) v = v | (q[i] << i);
    return v;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    mem_arbiter_if #(.XLEN(XLEN)) p0_if ();
    mem_arbiter_if #(.XLEN(XLEN)) p1_if ();
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_rstrb;
    logic [3:0]  mem_wmask;

    assign p0_if.rstrb = s_rstrb[0];
    assign p0_if.wmask = s_wmask[0];
    assign p0_if.addr  = s_addr[0];
    assign p0_if.wdata = s_wdata[0];
    assign p1_if.rstrb = s_rstrb[1];
    assign p1_if.wmask = s_wmask[1];
    assign p1_if.addr  = s_addr[1];
    assign p1_if.wdata = s_wdata[1];

    mem_arbiter #(.XLEN(XLEN), .PRIO_FIXED(k)) u_dut (
      .clk       (clk),
      .resetn    (resetn),
      .p0        (p0_if),
      .p1        (p1_if),
      .mem_addr  (mem_addr),
      .mem_rstrb (mem_rstrb),
      .mem_wmask (mem_wmask),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
    );

    // Memory emulation, word addressed, one-cycle read latency.
    logic [31:0] ram [logic [29:0]];
    logic [31:0] rw;
    int          wr_seen = 0;
    initial ram[30'h40] = 32'hDEADBEEF;

    always @(posedge clk) begin
      if (mem_wmask != 4'h0) begin
        wr_seen++;
        if (ram.exists(mem_addr[31:2])) rw = ram[mem_addr[31:2]];
        else rw = mem_default(mem_addr[31:2]);
        for (int b = 0; b < 4; b++) if (mem_wmask[b]) rw[8*b +: 8] = mem_wdata[8*b +: 8];
        ram[mem_addr[31:2]] = rw;
      end
      if (mem_rstrb) begin
        if (ram.exists(mem_addr[31:2])) mem_rdata <= ram[mem_addr[31:2]];
        else mem_rdata <= mem_default(mem_addr[31:2]);
      end
    end

    // Reference model: an access granted in idle cycle c occupies c+1..c+L
    // (L = 2 read, 1 write) and releases its port at the end of c+L.
    logic [31:0] mdl [logic [29:0]];
    initial mdl[30'h40] = 32'hDEADBEEF;
    logic        m_pend  [2];
    logic        m_isw   [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_wmask [2];
    logic [31:0] e_rdata [2];
    logic        e_rstrb;
    logic [3:0]  e_wmask;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] mw;
    bit          act, act_w, act_c;
    bit          busy_c [2];
    int          act_port, act_end, mcyc, last_g, g;
    int          oth [2];
    int          max_oth;
    int          glog [$];

    always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        for (int p = 0; p < 2; p++) begin
          m_pend[p]  = 1'b0;
          m_isw[p]   = 1'b0;
          e_rdata[p] = '0;
          oth[p]     = 0;
        end
        e_rstrb = 1'b0;
        e_wmask = '0;
        e_addr  = '0;
        e_wdata = '0;
        act     = 1'b0;
        last_g  = 1;
        mcyc    = 0;
        max_oth = 0;
        glog.delete();
      end else begin
        busy_c[0] = m_pend[0];
        busy_c[1] = m_pend[1];
        act_c     = act;
        if (act && mcyc == act_end) begin
          if (mdl.exists(m_addr[act_port][31:2])) mw = mdl[m_addr[act_port][31:2]];
          else mw = mem_default(m_addr[act_port][31:2]);
          if (act_w) begin
            for (int b = 0; b < 4; b++)
              if (m_wmask[act_port][b]) mw[8*b +: 8] = m_wdata[act_port][8*b +: 8];
            mdl[m_addr[act_port][31:2]] = mw;
          end else begin
            e_rdata[act_port] = mw;
          end
          m_pend[act_port] = 1'b0;
          act = 1'b0;
        end
        e_rstrb = 1'b0;
        e_wmask = '0;
        if (!act_c && (busy_c[0] || busy_c[1])) begin
          if (busy_c[0] && busy_c[1]) g = (k == 1) ? 0 : 1 - last_g;
          else g = busy_c[0] ? 0 : 1;
          if (busy_c[1-g]) begin
            oth[1-g]++;
            if (oth[1-g] > max_oth) max_oth = oth[1-g];
          end
          oth[g]   = 0;
          last_g   = g;
          glog.push_back(g);
          act      = 1'b1;
          act_port = g;
          act_w    = m_isw[g];
          act_end  = mcyc + (act_w ? 1 : 2);
          e_addr   = m_addr[g];
          if (act_w) begin
            e_wmask = m_wmask[g];
            e_wdata = m_wdata[g];
          end else begin
            e_rstrb = 1'b1;
          end
        end
        for (int p = 0; p < 2; p++) begin
          if (!busy_c[p] && (s_rstrb[p] || s_wmask[p] != 4'h0)) begin
            m_pend[p]  = 1'b1;
            m_isw[p]   = (s_wmask[p] != 4'h0);
            m_addr[p]  = s_addr[p];
            m_wdata[p] = s_wdata[p];
            m_wmask[p] = s_wmask[p];
          end
        end
        mcyc++;
      end
    end

    always @(negedge clk) begin
      chk("mem_rstrb", k, 32'(mem_rstrb), 32'(e_rstrb));
      chk("mem_wmask", k, 32'(mem_wmask), 32'(e_wmask));
      chk("mem_addr",  k, mem_addr, e_addr);
      chk("mem_wdata", k, mem_wdata, e_wdata);
      chk("p0_rdata",  k, p0_if.rdata, e_rdata[0]);
      chk("p1_rdata",  k, p1_if.rdata, e_rdata[1]);
      chk("p0_rbusy",  k, 32'(p0_if.rbusy), 32'(m_pend[0] && !m_isw[0]));
      chk("p0_wbusy",  k, 32'(p0_if.wbusy), 32'(m_pend[0] && m_isw[0]));
      chk("p1_rbusy",  k, 32'(p1_if.rbusy), 32'(m_pend[1] && !m_isw[1]));
      chk("p1_wbusy",  k, 32'(p1_if.wbusy), 32'(m_pend[1] && m_isw[1]));
    end
  end

  task automatic tick();
    @(negedge clk);
    tc++;
    for (int p = 0; p < 2; p++) begin
      s_rstrb[p] = 1'b0;
      s_wmask[p] = 4'h0;
    end
  endtask

  task automatic rd(input int p, input logic [31:0] a);
    s_rstrb[p] = 1'b1;
    s_addr[p]  = a;
  endtask

  task automatic wr(input int p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    s_wmask[p] = m;
    s_addr[p]  = a;
    s_wdata[p] = d;
  endtask

  task automatic do_reset();
    tick();
    #2 resetn = 1'b0;
    repeat (2) tick();
    #2 resetn = 1'b1;
    tick();
    tc = 0;
  endtask

  int n0, n1, ws0, ws1;

  initial begin
    resetn = 1'b0;
    for (int p = 0; p < 2; p++) begin
      s_rstrb[p] = 1'b0;
      s_wmask[p] = 4'h0;
      s_addr[p]  = '0;
      s_wdata[p] = '0;
    end
    do_reset();
    chk("rst_mem_addr", 0, g_dut[0].mem_addr, 32'h0);
    chk("rst_p0_rdata", 1, g_dut[1].p0_if.rdata, 32'h0);

    // Uncontended read of 0x100.
    rd(0, 32'h100);
    tick();
    chk("t1_rbusy_c1", 0, 32'(g_dut[0].p0_if.rbusy), 32'h1);
    chk("t1_rstrb_c1", 0, 32'(g_dut[0].mem_rstrb), 32'h0);
    tick();
    chk("t1_rstrb_c2", 0, 32'(g_dut[0].mem_rstrb), 32'h1);
    chk("t1_addr_c2",  0, g_dut[0].mem_addr, 32'h100);
    tick();
    chk("t1_rbusy_c3", 0, 32'(g_dut[0].p0_if.rbusy), 32'h1);
    chk("t1_rstrb_c3", 0, 32'(g_dut[0].mem_rstrb), 32'h0);
    tick();
    chk("t1_rbusy_c4", 0, 32'(g_dut[0].p0_if.rbusy), 32'h0);
    chk("t1_rdata_c4", 0, g_dut[0].p0_if.rdata, 32'hDEADBEEF);
    chk("t1_rdata_c4", 1, g_dut[1].p0_if.rdata, 32'hDEADBEEF);

    // Re-strobe immediately, then reset while the read is on the bus.
    rd(0, 32'h10);
    tick();
    tick();
    chk("t6_rstrb_pre", 0, 32'(g_dut[0].mem_rstrb), 32'h1);
    #2 resetn = 1'b0;
    #1;
    for (int i = 0; i < 1; i++) begin
      chk("t6_rstrb_rst", 0, 32'(g_dut[0].mem_rstrb), 32'h0);
      chk("t6_rbusy_rst", 0, 32'(g_dut[0].p0_if.rbusy), 32'h0);
      chk("t6_rdata_rst", 0, g_dut[0].p0_if.rdata, 32'h0);
      chk("t6_rdata_rst", 1, g_dut[1].p0_if.rdata, 32'h0);
    end
    repeat (2) tick();
    #2 resetn = 1'b1;
    repeat (6) tick();
    chk("t6_rdata_post", 0, g_dut[0].p0_if.rdata, 32'h0);
    chk("t6_rbusy_post", 0, 32'(g_dut[0].p0_if.rbusy), 32'h0);

    // Simultaneous p0 read and p1 write right after reset.
    do_reset();
    rd(0, 32'h10);
    wr(1, 32'h20, 32'h12345678, 4'hF);
    tick();
    tick();
    chk("t2_rstrb_c2", 0, 32'(g_dut[0].mem_rstrb), 32'h1);
    chk("t2_addr_c2",  0, g_dut[0].mem_addr, 32'h10);
    tick();
    tick();
    chk("t2_rdata_c4", 0, g_dut[0].p0_if.rdata, 32'hC0DE0010);
    tick();
    chk("t2_wmask_c5", 0, 32'(g_dut[0].mem_wmask), 32'hF);
    chk("t2_addr_c5",  0, g_dut[0].mem_addr, 32'h20);
    chk("t2_wdata_c5", 0, g_dut[0].mem_wdata, 32'h12345678);
    chk("t2_wbusy_c5", 0, 32'(g_dut[0].p1_if.wbusy), 32'h1);
    tick();
    chk("t2_wbusy_c6", 0, 32'(g_dut[0].p1_if.wbusy), 32'h0);

    // p0 goes alone, then a tie: round-robin favours p1, fixed priority p0.
    tick();
    tc = 0;
    rd(0, 32'h30);
    repeat (4) tick();
    rd(0, 32'h34);
    rd(1, 32'h38);
    tick();
    tick();
    chk("tie_addr_rr",  0, g_dut[0].mem_addr, 32'h38);
    chk("tie_addr_fix", 1, g_dut[1].mem_addr, 32'h34);
    repeat (6) tick();
    chk("tie_log_rr",  0, pack_log(g_dut[0].glog), 32'h0A);
    chk("tie_log_fix", 1, pack_log(g_dut[1].glog), 32'h12);
    chk("tie_log_len", 0, g_dut[0].glog.size(), 32'd5);

    // Both ports re-strobe reads as soon as they are free.
    do_reset();
    n0 = 0;
    n1 = 0;
    for (int c = 0; c < 40; c++) begin
      if (!g_dut[0].m_pend[0] && n0 < 5) begin rd(0, 32'h200 + 32'(n0) * 4); n0++; end
      if (!g_dut[0].m_pend[1] && n1 < 5) begin rd(1, 32'h300 + 32'(n1) * 4); n1++; end
      tick();
    end
    chk("rr_log",     0, pack_log(g_dut[0].glog), 32'h2AA);
    chk("rr_log",     1, pack_log(g_dut[1].glog), 32'h2AA);
    chk("rr_len",     0, g_dut[0].glog.size(), 32'd10);
    chk("rr_maxwait", 0, g_dut[0].max_oth, 32'd1);
    chk("rr_maxwait", 1, g_dut[1].max_oth, 32'd1);
    chk("rr_p0_last", 0, g_dut[0].p0_if.rdata, 32'hC0DE0210);
    chk("rr_p1_last", 1, g_dut[1].p1_if.rdata, 32'hC0DE0310);

    // Single-lane write; a second strobe while busy must vanish.
    tick();
    tc = 0;
    ws0 = g_dut[0].wr_seen;
    ws1 = g_dut[1].wr_seen;
    wr(1, 32'h41, 32'h0000AB00, 4'h2);
    tick();
    wr(1, 32'h44, 32'h00CD0000, 4'h4);
    tick();
    chk("t5_wmask", 0, 32'(g_dut[0].mem_wmask), 32'h2);
    chk("t5_addr",  0, g_dut[0].mem_addr, 32'h41);
    chk("t5_wdata", 0, g_dut[0].mem_wdata, 32'h0000AB00);
    repeat (4) tick();
    rd(0, 32'h40);
    repeat (4) tick();
    chk("t5_readback", 0, g_dut[0].p0_if.rdata, 32'hC0DEAB40);
    chk("t5_nwrites",  0, g_dut[0].wr_seen - ws0, 32'd1);
    chk("t5_nwrites",  1, g_dut[1].wr_seen - ws1, 32'd1);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
